fetch_ctrl: RTL

- Front-end sequencer for the IF/ID pipeline register and the PC register.
- Generates IF/ID write-enable and clear, and the PC write-enable.
- Runs the ITLB-miss refill handshake and raises instruction-fetch exceptions.
- Sits between fetch, the hazard unit, and the ITLB refill walker.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_refill_timer.sv | 32 +++
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end types: fetch FSM states, address type and default exception vector.
package cpu_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MISS,
        ST_REPLAY,
        ST_EXC,
        ST_DRAIN
    } fetch_state_e;

    localparam addr_t EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/fetch_refill_timer.sv
// Saturating up-counter timing the ITLB refill wait; terminal marks the last allowed wait cycle.
module fetch_refill_timer #(
    parameter int unsigned LIMIT = 64,
    localparam int unsigned W = $clog2(LIMIT + 1)
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

    // High on the cycle whose increment brings the count to LIMIT.
    assign terminal = (count >= W'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// IF/ID and PC sequencing with the ITLB-miss refill handshake and fetch exceptions.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REFILL_TIMEOUT = 64,
    parameter addr_t       EXC_VECTOR     = EXC_VECTOR_DEFAULT
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        hazard_stall,
    input  logic        flush_ex,
    input  logic        jump_decode,
    input  logic        itlb_miss,
    input  logic        itlb_ready,
    input  logic [31:0] fetch_pc,
    input  logic        refill_ack,
    input  logic        refill_ok,
    output logic        refill_req,
    output logic [31:0] refill_vaddr,
    output logic        if_id_we,
    output logic        if_id_clear,
    output logic        pc_we,
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic [31:0] exc_redirect_pc
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] perf_itlb_miss,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int unsigned TW = $clog2(REFILL_TIMEOUT + 1);

    fetch_state_e state;
    logic         flush;
    logic         miss_take;
    logic         tmr_clear;
    logic         tmr_load;
    logic         tmr_en;
    logic         tmr_terminal;

    assign flush           = flush_ex | jump_decode;
    assign miss_take       = (state == ST_RUN) && !flush && itlb_miss && itlb_ready;
    assign exc_redirect_pc = EXC_VECTOR;

    assign tmr_load  = miss_take;
    assign tmr_en    = (state == ST_MISS);
    assign tmr_clear = (state == ST_REPLAY) || ((state == ST_MISS) && refill_ack && flush);

    fetch_refill_timer #(
        .LIMIT (REFILL_TIMEOUT)
    ) u_timer (
        .clock      (clock),
        .rst        (rst),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value ('0),
        .en         (tmr_en),
        .terminal   (tmr_terminal)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state        <= ST_RUN;
            refill_req   <= 1'b0;
            refill_vaddr <= '0;
            exc_valid    <= 1'b0;
            exc_addr     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (miss_take) begin
                        state        <= ST_MISS;
                        refill_req   <= 1'b1;
                        refill_vaddr <= fetch_pc;
                    end
                end
                ST_MISS: begin
                    if (refill_ack) begin
                        refill_req <= 1'b0;
                        if (flush) begin
                            state <= ST_RUN;
                        end else if (refill_ok) begin
                            state <= ST_REPLAY;
                        end else begin
                            state     <= ST_EXC;
                            exc_valid <= 1'b1;
                            exc_addr  <= refill_vaddr;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end else if (tmr_terminal) begin
                        // Timeout leaves refill_req up; the late ack is absorbed in DRAIN.
                        state     <= ST_EXC;
                        exc_valid <= 1'b1;
                        exc_addr  <= refill_vaddr;
                    end
                end
                ST_REPLAY: begin
                    state <= ST_RUN;
                end
                ST_EXC: begin
                    exc_valid <= 1'b0;
                    if (refill_req && !refill_ack) begin
                        state <= ST_DRAIN;
                    end else begin
                        refill_req <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (refill_ack) begin
                        refill_req <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        if_id_we    = 1'b0;
        if_id_clear = 1'b1;
        pc_we       = 1'b0;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    pc_we = 1'b1;
                end else if (!(itlb_miss && itlb_ready)) begin
                    if_id_we    = !hazard_stall;
                    pc_we       = !hazard_stall;
                    if_id_clear = 1'b0;
                end
            end
            ST_EXC: begin
                pc_we = 1'b1;
            end
            default: begin
                pc_we = 1'b0;
            end
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            perf_itlb_miss    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (miss_take && (perf_itlb_miss != '1)) begin
                perf_itlb_miss <= perf_itlb_miss + 32'd1;
            end
            if (!pc_we && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

    logic unused_tw;
    assign unused_tw = ^TW;

endmodule
